// File: rtl/wasm_cpu.sv
// Sequential WebAssembly subset interpreter.
// Fetches an opcode, then its immediate, then retires against an on-chip operand stack.
module wasm_cpu #(
  parameter int HAS_FPU     = 1,
  parameter int USE_64B     = 1,
  parameter int MEM_DEPTH   = 6,
  parameter int STACK_DEPTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_DEPTH:0]   pc,
  input  logic [STACK_DEPTH:0] index,
  output logic [63:0]          result,
  output logic [1:0]           result_type,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);

  localparam int SW    = STACK_DEPTH + 1;
  localparam int NSLOT = 1 << SW;

  typedef logic [SW-1:0]      sidx_t;
  typedef logic [MEM_DEPTH:0] addr_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC
  } state_t;

  typedef struct packed {
    logic [3:0]  len;
    logic [63:0] val;
  } leb_t;

  localparam logic [3:0] T_NONE     = 4'd0;
  localparam logic [3:0] T_ENDED    = 4'd1;
  localparam logic [3:0] T_UNREACH  = 4'd2;
  localparam logic [3:0] T_UNKNOWN  = 4'd3;
  localparam logic [3:0] T_EMPTY    = 4'd4;
  localparam logic [3:0] T_OVERFLOW = 4'd5;
  localparam logic [3:0] T_MEM      = 4'd6;
  localparam logic [3:0] T_NO_FPU   = 4'd7;
  localparam logic [3:0] T_NO_64B   = 4'd8;
  localparam logic [3:0] T_TYPE     = 4'd9;
  localparam logic [3:0] T_BAD_LOC  = 4'd10;

  localparam logic [7:0] OP_UNREACH = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'h01;
  localparam logic [7:0] OP_END     = 8'h0B;
  localparam logic [7:0] OP_DROP    = 8'h1A;
  localparam logic [7:0] OP_GET     = 8'h20;
  localparam logic [7:0] OP_SET     = 8'h21;
  localparam logic [7:0] OP_TEE     = 8'h22;
  localparam logic [7:0] OP_I32C    = 8'h41;
  localparam logic [7:0] OP_I64C    = 8'h42;
  localparam logic [7:0] OP_F32C    = 8'h43;
  localparam logic [7:0] OP_F64C    = 8'h44;
  localparam logic [7:0] OP_I32ADD  = 8'h6A;
  localparam logic [7:0] OP_I64ADD  = 8'h7C;

  // LEB128 over at most nmax window bytes; an unterminated run uses them all.
  function automatic leb_t leb_dec(
    input logic [127:0] d,
    input int           nmax,
    input logic         sgn
  );
    leb_t r;
    logic done;
    r.val = '0;
    r.len = 4'(nmax);
    done  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!done && k < nmax) begin
        r.val = r.val | ({57'd0, d[8*k +: 7]} << (7 * k));
        if (!d[8*k+7]) begin
          done  = 1'b1;
          r.len = 4'(k + 1);
          if (sgn && d[8*k+6] && k < 9)
            r.val = r.val | ({64{1'b1}} << (7 * (k + 1)));
        end
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  addr_t       pc_q, pc_d;
  sidx_t       base_q;
  sidx_t       sp_q, sp_d;
  logic [7:0]  op_q, op_d;
  logic [3:0]  trap_q, trap_d;
  logic [63:0] res_q, res_d;
  logic [1:0]  rty_q, rty_d;
  logic        empty_q, empty_d;
  addr_t       maddr_q, maddr_d;
  logic [3:0]  mext_q, mext_d;

  logic [63:0] stk_val [NSLOT];
  logic [1:0]  stk_ty  [NSLOT];

  logic        wr_en;
  sidx_t       wr_idx;
  logic [63:0] wr_val;
  logic [1:0]  wr_ty;

  sidx_t       top_i, nxt_i, loc_i;
  logic [63:0] top_v, nxt_v, loc_v;
  logic [1:0]  top_t, nxt_t, loc_t;
  logic        has1, has2, full, bad_loc;
  logic [7:0]  dop;
  logic        need64, needfpu;
  leb_t        lv;
  logic [63:0] imm_v;
  logic [3:0]  imm_len;

  logic        go, do_push, do_pop, do_loc, do_add;
  addr_t       npc;
  logic [63:0] pv, add_v;
  logic [1:0]  pt, add_t;

  logic unused_mem;
  assign unused_mem = ^mem_data[127:80];

  assign top_i = sp_q - sidx_t'(1);
  assign nxt_i = sp_q - sidx_t'(2);
  assign top_v = stk_val[top_i];
  assign top_t = stk_ty[top_i];
  assign nxt_v = stk_val[nxt_i];
  assign nxt_t = stk_ty[nxt_i];
  assign has1  = sp_q != base_q;
  assign has2  = (sp_q - base_q) > sidx_t'(1);
  assign full  = sp_q == '1;

  assign dop     = mem_data[7:0];
  assign need64  = (USE_64B == 0) &&
                   (dop == OP_I64C || dop == OP_I64ADD);
  assign needfpu = (HAS_FPU == 0) &&
                   (dop == OP_F32C || dop == OP_F64C);

  always_comb begin
    lv = leb_dec(mem_data,
                 (op_q == OP_I64C) ? 10 : 5,
                 op_q == OP_I32C || op_q == OP_I64C);
    imm_v   = lv.val;
    imm_len = lv.len;
    if (op_q == OP_F32C) begin
      imm_v   = {32'd0, mem_data[31:0]};
      imm_len = 4'd4;
    end else if (op_q == OP_F64C) begin
      imm_v   = mem_data[63:0];
      imm_len = 4'd8;
    end
  end

  assign loc_i   = imm_v[SW-1:0];
  assign loc_v   = stk_val[loc_i];
  assign loc_t   = stk_ty[loc_i];
  assign bad_loc = imm_v >= 64'(base_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    op_d    = op_q;
    trap_d  = trap_q;
    res_d   = res_q;
    rty_d   = rty_q;
    empty_d = empty_q;
    maddr_d = maddr_q;
    mext_d  = mext_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q;
    wr_val  = '0;
    wr_ty   = '0;
    go      = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_loc  = 1'b0;
    do_add  = 1'b0;
    npc     = pc_q + addr_t'(1);
    pv      = '0;
    pt      = '0;
    add_v   = '0;
    add_t   = '0;
    if (trap_q == T_NONE) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (mem_error)    trap_d = T_MEM;
          else if (need64)  trap_d = T_NO_64B;
          else if (needfpu) trap_d = T_NO_FPU;
          else begin
            case (dop)
              OP_UNREACH: trap_d = T_UNREACH;
              OP_NOP:     go = 1'b1;
              OP_END:     trap_d = T_ENDED;
              OP_DROP: begin
                if (!has1) trap_d = T_EMPTY;
                else begin
                  do_pop = 1'b1;
                  go     = 1'b1;
                end
              end
              OP_I32ADD, OP_I64ADD: begin
                add_t = (dop == OP_I64ADD) ? 2'd1 : 2'd0;
                if (!has2) trap_d = T_EMPTY;
                else if (top_t != add_t || nxt_t != add_t)
                  trap_d = T_TYPE;
                else begin
                  do_add = 1'b1;
                  go     = 1'b1;
                end
                add_v = top_v + nxt_v;
                if (add_t == 2'd0) add_v = {32'd0, add_v[31:0]};
              end
              OP_GET, OP_SET, OP_TEE, OP_I32C,
              OP_I64C, OP_F32C, OP_F64C: begin
                op_d    = dop;
                maddr_d = pc_q + addr_t'(1);
                state_d = S_IMM;
                case (dop)
                  OP_I64C: mext_d = 4'd9;
                  OP_F32C: mext_d = 4'd3;
                  OP_F64C: mext_d = 4'd7;
                  default: mext_d = 4'd4;
                endcase
              end
              default: trap_d = T_UNKNOWN;
            endcase
          end
        end
        S_IMM: state_d = S_EXEC;
        S_EXEC: begin
          npc = pc_q + addr_t'(imm_len) + addr_t'(1);
          if (mem_error) trap_d = T_MEM;
          else begin
            case (op_q)
              OP_GET: begin
                if (bad_loc)   trap_d = T_BAD_LOC;
                else if (full) trap_d = T_OVERFLOW;
                else begin
                  do_push = 1'b1;
                  pv      = loc_v;
                  pt      = loc_t;
                end
              end
              OP_SET, OP_TEE: begin
                if (!has1)        trap_d = T_EMPTY;
                else if (bad_loc) trap_d = T_BAD_LOC;
                else begin
                  do_loc = 1'b1;
                  do_pop = op_q == OP_SET;
                end
              end
              OP_I32C, OP_I64C, OP_F32C, OP_F64C: begin
                if (full) trap_d = T_OVERFLOW;
                else begin
                  do_push = 1'b1;
                  pt      = 2'(op_q - OP_I32C);
                  pv      = (op_q == OP_I32C) ?
                            {32'd0, imm_v[31:0]} : imm_v;
                end
              end
              default: trap_d = T_UNKNOWN;
            endcase
            go = trap_d == T_NONE;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    if (do_push) begin
      wr_en   = 1'b1;
      wr_idx  = sp_q;
      wr_val  = pv;
      wr_ty   = pt;
      sp_d    = sp_q + sidx_t'(1);
      res_d   = pv;
      rty_d   = pt;
      empty_d = 1'b0;
    end
    if (do_loc) begin
      wr_en  = 1'b1;
      wr_idx = loc_i;
      wr_val = top_v;
      wr_ty  = top_t;
    end
    if (do_pop) begin
      sp_d = top_i;
      if (top_i == base_q) begin
        res_d   = '0;
        rty_d   = '0;
        empty_d = 1'b1;
      end else begin
        res_d = nxt_v;
        rty_d = nxt_t;
      end
    end
    if (do_add) begin
      wr_en  = 1'b1;
      wr_idx = nxt_i;
      wr_val = add_v;
      wr_ty  = add_t;
      sp_d   = top_i;
      res_d  = add_v;
      rty_d  = add_t;
    end
    if (go) begin
      pc_d    = npc;
      maddr_d = npc;
      mext_d  = 4'd0;
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= pc;
      base_q  <= index;
      sp_q    <= index;
      op_q    <= 8'd0;
      trap_q  <= T_NONE;
      res_q   <= '0;
      rty_q   <= '0;
      empty_q <= 1'b1;
      maddr_q <= pc;
      mext_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      op_q    <= op_d;
      trap_q  <= trap_d;
      res_q   <= res_d;
      rty_q   <= rty_d;
      empty_q <= empty_d;
      maddr_q <= maddr_d;
      mext_q  <= mext_d;
    end
  end

  // Locals stay undefined until written, so the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      stk_val[wr_idx] <= wr_val;
      stk_ty[wr_idx]  <= wr_ty;
    end
  end

  assign result       = res_q;
  assign result_type  = rty_q;
  assign result_empty = empty_q;
  assign trap         = trap_q;
  assign mem_addr     = maddr_q;
  assign mem_extra    = mext_q;

endmodule

// File: tb/tb_wasm_cpu.sv
// Bench for wasm_cpu: byte memory model, instruction-level
// interpreter as reference, directed and random programs.
module tb_wasm_cpu;

  localparam int UPPER = 99;

  localparam logic [7:0] OP_UNREACH = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'h01;
  localparam logic [7:0] OP_END     = 8'h0B;
  localparam logic [7:0] OP_DROP    = 8'h1A;
  localparam logic [7:0] OP_GET     = 8'h20;
  localparam logic [7:0] OP_SET     = 8'h21;
  localparam logic [7:0] OP_TEE     = 8'h22;
  localparam logic [7:0] OP_I32C    = 8'h41;
  localparam logic [7:0] OP_I64C    = 8'h42;
  localparam logic [7:0] OP_F32C    = 8'h43;
  localparam logic [7:0] OP_F64C    = 8'h44;
  localparam logic [7:0] OP_I32ADD  = 8'h6A;
  localparam logic [7:0] OP_I64ADD  = 8'h7C;

  typedef struct {
    logic [7:0] op;
    longint     imm;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [6:0]   pc_in = '0;
  logic [7:0]   idx_in = '0;

  logic [63:0]  res, res_n;
  logic [1:0]   rty, rty_n;
  logic         remp, remp_n;
  logic [3:0]   trp, trp_n;
  logic [6:0]   maddr, maddr_n;
  logic [3:0]   mext, mext_n;
  logic [127:0] mdat = '0, mdat_n = '0;
  logic         merr = 1'b0, merr_n = 1'b0;

  wasm_cpu dut (
    .clk(clk), .reset(reset), .pc(pc_in), .index(idx_in),
    .result(res), .result_type(rty), .result_empty(remp),
    .trap(trp), .mem_addr(maddr), .mem_extra(mext),
    .mem_data(mdat), .mem_error(merr)
  );

  wasm_cpu #(.HAS_FPU(0), .USE_64B(0)) dut_n (
    .clk(clk), .reset(reset), .pc(pc_in), .index(idx_in),
    .result(res_n), .result_type(rty_n), .result_empty(remp_n),
    .trap(trp_n), .mem_addr(maddr_n), .mem_extra(mext_n),
    .mem_data(mdat_n), .mem_error(merr_n)
  );

  logic [7:0] mem [128];
  int n_chk = 0;
  int n_fail = 0;
  int wp;
  int addrs[$];

  function automatic logic [127:0] win(input logic [6:0] a);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++)
      if (int'(a) + k < 128) w[8*k +: 8] = mem[int'(a) + k];
    return w;
  endfunction

  always @(posedge clk) begin
    mdat   <= win(maddr);
    merr   <= (int'(maddr) + int'(mext)) > UPPER;
    mdat_n <= win(maddr_n);
    merr_n <= (int'(maddr_n) + int'(mext_n)) > UPPER;
  end

  function automatic ins_t mk(input logic [7:0] o, input longint i);
    ins_t r;
    r.op  = o;
    r.imm = i;
    return r;
  endfunction

  task automatic put(input logic [7:0] b);
    if (wp < 128) mem[wp] = b;
    wp++;
  endtask

  task automatic put_uleb(input longint unsigned v);
    logic [7:0] b;
    do begin
      b = {1'b0, v[6:0]};
      v = v >> 7;
      if (v != 0) b[7] = 1'b1;
      put(b);
    end while (v != 0);
  endtask

  task automatic put_sleb(input longint v);
    logic [7:0] b;
    bit done;
    do begin
      b = {1'b0, v[6:0]};
      v = v >>> 7;
      done = (v == 0 && !b[6]) || (v == -1 && b[6]);
      if (!done) b[7] = 1'b1;
      put(b);
    end while (!done);
  endtask

  task automatic load(input ins_t p[$], input int start);
    logic [63:0] raw;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    wp = start;
    addrs.delete();
    foreach (p[i]) begin
      addrs.push_back(wp);
      put(p[i].op);
      raw = p[i].imm;
      case (p[i].op)
        OP_GET, OP_SET, OP_TEE: put_uleb(p[i].imm);
        OP_I32C: put_sleb(longint'(int'(p[i].imm)));
        OP_I64C: put_sleb(p[i].imm);
        OP_F32C: for (int k = 0; k < 4; k++) put(raw[8*k +: 8]);
        OP_F64C: for (int k = 0; k < 8; k++) put(raw[8*k +: 8]);
        default: ;
      endcase
    end
  endtask

  // Interprets the instruction list directly, one step per instruction.
  function automatic void model(
    input ins_t p[$], input int base, input bit fpu, input bit b64,
    output int t, output logic [63:0] v, output int ty, output bit emp
  );
    logic [63:0] sv [256];
    int st [256];
    int sp, a, ext, li;
    logic [7:0] op;
    sp = base;
    t  = 0;
    for (int i = 0; i < 256; i++) begin
      sv[i] = '0;
      st[i] = 0;
    end
    for (int i = 0; i < p.size() && t == 0; i++) begin
      op = p[i].op;
      a  = addrs[i];
      case (op)
        OP_GET, OP_SET, OP_TEE, OP_I32C: ext = 4;
        OP_I64C: ext = 9;
        OP_F32C: ext = 3;
        OP_F64C: ext = 7;
        default: ext = -1;
      endcase
      li = (p[i].imm >= 0 && p[i].imm < 256) ? int'(p[i].imm) : 255;
      if (a > UPPER) t = 6;
      else if (!b64 && (op == OP_I64C || op == OP_I64ADD)) t = 8;
      else if (!fpu && (op == OP_F32C || op == OP_F64C)) t = 7;
      else if (ext >= 0 && a + 1 + ext > UPPER) t = 6;
      else begin
        case (op)
          OP_UNREACH: t = 2;
          OP_NOP: ;
          OP_END: t = 1;
          OP_DROP: if (sp == base) t = 4; else sp--;
          OP_I32ADD, OP_I64ADD: begin
            if (sp - base < 2) t = 4;
            else if (st[sp-1] != (op == OP_I64ADD ? 1 : 0) ||
                     st[sp-2] != (op == OP_I64ADD ? 1 : 0)) t = 9;
            else begin
              sv[sp-2] = sv[sp-1] + sv[sp-2];
              if (op == OP_I32ADD) sv[sp-2] = sv[sp-2] & 64'hFFFF_FFFF;
              sp--;
            end
          end
          OP_I32C, OP_I64C, OP_F32C, OP_F64C: begin
            if (sp == 255) t = 5;
            else begin
              sv[sp] = p[i].imm;
              if (op == OP_I32C || op == OP_F32C)
                sv[sp] = sv[sp] & 64'hFFFF_FFFF;
              st[sp] = int'(op) - 8'h41;
              sp++;
            end
          end
          OP_GET: begin
            if (p[i].imm >= base) t = 10;
            else if (sp == 255) t = 5;
            else begin
              sv[sp] = sv[li];
              st[sp] = st[li];
              sp++;
            end
          end
          OP_SET, OP_TEE: begin
            if (sp == base) t = 4;
            else if (p[i].imm >= base) t = 10;
            else begin
              sv[li] = sv[sp-1];
              st[li] = st[sp-1];
              if (op == OP_SET) sp--;
            end
          end
          default: t = 3;
        endcase
      end
    end
    if (t == 0) t = (wp > UPPER) ? 6 : 2;
    emp = sp == base;
    v   = emp ? 64'd0 : sv[sp-1];
    ty  = emp ? 0 : st[sp-1];
  endfunction

  task automatic exec_prog(
    input int start, input int idx, input bit sel_n, input int budget,
    output int cyc, output bit done
  );
    @(negedge clk);
    reset  = 1'b1;
    pc_in  = 7'(start);
    idx_in = 8'(idx);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    done  = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      done = sel_n ? (trp_n != 4'd0) : (trp != 4'd0);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; pc_in = 7'd42; idx_in = 8'd3;
    repeat (2) @(negedge clk);
    n_chk++; if (trp !== 4'd0) begin n_fail++; $display("FAIL reset_trap got %0d want 0", trp); end
    n_chk++; if (res !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", res); end
    n_chk++; if (rty !== 2'd0) begin n_fail++; $display("FAIL reset_type got %0d want 0", rty); end
    n_chk++; if (remp !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", remp); end
    n_chk++; if (maddr !== 7'd42) begin n_fail++; $display("FAIL reset_addr got %0d want 42", maddr); end
    n_chk++; if (mext !== 4'd0) begin n_fail++; $display("FAIL reset_extra got %0d want 0", mext); end
  endtask

  task automatic test_i64_locals;
    ins_t p[$];
    int cyc; bit done;
    p.push_back(mk(OP_I64C, 3)); p.push_back(mk(OP_SET, 0));
    p.push_back(mk(OP_GET, 0)); p.push_back(mk(OP_END, 0));
    load(p, 17);
    exec_prog(17, 1, 1'b0, 22, cyc, done);
    n_chk++; if (!done) begin n_fail++; $display("FAIL i64_timeout got %0d cycles want <=22", cyc); end
    n_chk++; if (res !== 64'd3) begin n_fail++; $display("FAIL i64_result got %h want 3", res); end
    n_chk++; if (rty !== 2'd1) begin n_fail++; $display("FAIL i64_type got %0d want 1", rty); end
    n_chk++; if (remp !== 1'b0) begin n_fail++; $display("FAIL i64_empty got %0b want 0", remp); end
    n_chk++; if (trp !== 4'd1) begin n_fail++; $display("FAIL i64_trap got %0d want 1", trp); end
    exec_prog(17, 1, 1'b1, 6, cyc, done);
    n_chk++; if (trp_n !== 4'd8) begin n_fail++; $display("FAIL no64_trap got %0d want 8", trp_n); end
    n_chk++; if (remp_n !== 1'b1) begin n_fail++; $display("FAIL no64_empty got %0b want 1", remp_n); end
  endtask

  task automatic test_i32_add;
    ins_t p[$];
    int cyc; bit done;
    p.push_back(mk(OP_I32C, -1)); p.push_back(mk(OP_I32C, 2));
    p.push_back(mk(OP_I32ADD, 0)); p.push_back(mk(OP_END, 0));
    load(p, 0);
    exec_prog(0, 0, 1'b0, 30, cyc, done);
    n_chk++; if (res !== 64'd1) begin n_fail++; $display("FAIL add32_result got %h want 1", res); end
    n_chk++; if (rty !== 2'd0) begin n_fail++; $display("FAIL add32_type got %0d want 0", rty); end
    n_chk++; if (trp !== 4'd1) begin n_fail++; $display("FAIL add32_trap got %0d want 1", trp); end
  endtask

  task automatic test_stack_errors;
    ins_t p[$];
    int cyc; bit done;
    p.push_back(mk(OP_DROP, 0));
    load(p, 5);
    exec_prog(5, 0, 1'b0, 20, cyc, done);
    n_chk++; if (trp !== 4'd4) begin n_fail++; $display("FAIL drop_empty got %0d want 4", trp); end
    p.delete();
    p.push_back(mk(OP_I32C, 5)); p.push_back(mk(OP_SET, 0));
    load(p, 5);
    exec_prog(5, 0, 1'b0, 20, cyc, done);
    n_chk++; if (trp !== 4'd10) begin n_fail++; $display("FAIL bad_local got %0d want 10", trp); end
    n_chk++; if (res !== 64'd5) begin n_fail++; $display("FAIL bad_local_top got %h want 5", res); end
    p.delete();
    p.push_back(mk(OP_I32C, 1)); p.push_back(mk(OP_I64C, 1));
    p.push_back(mk(OP_I64ADD, 0));
    load(p, 5);
    exec_prog(5, 0, 1'b0, 30, cyc, done);
    n_chk++; if (trp !== 4'd9) begin n_fail++; $display("FAIL mismatch got %0d want 9", trp); end
    n_chk++; if (rty !== 2'd1) begin n_fail++; $display("FAIL mismatch_type got %0d want 1", rty); end
    p.delete();
    p.push_back(mk(OP_I32C, 1)); p.push_back(mk(OP_I32C, 2));
    p.push_back(mk(OP_END, 0));
    load(p, 5);
    exec_prog(5, 254, 1'b0, 30, cyc, done);
    n_chk++; if (trp !== 4'd5) begin n_fail++; $display("FAIL overflow got %0d want 5", trp); end
    n_chk++; if (res !== 64'd1) begin n_fail++; $display("FAIL overflow_top got %h want 1", res); end
  endtask

  task automatic test_mem_bounds;
    ins_t p[$];
    int cyc; bit done;
    p.push_back(mk(OP_I32C, 7));
    load(p, UPPER);
    exec_prog(UPPER, 0, 1'b0, 20, cyc, done);
    n_chk++; if (trp !== 4'd6) begin n_fail++; $display("FAIL mem_imm got %0d want 6", trp); end
    p.delete();
    p.push_back(mk(OP_END, 0));
    load(p, UPPER);
    exec_prog(UPPER, 0, 1'b0, 20, cyc, done);
    n_chk++; if (trp !== 4'd1) begin n_fail++; $display("FAIL mem_edge_end got %0d want 1", trp); end
    p.delete();
    p.push_back(mk(OP_NOP, 0));
    load(p, UPPER);
    exec_prog(UPPER, 0, 1'b0, 20, cyc, done);
    n_chk++; if (trp !== 4'd6) begin n_fail++; $display("FAIL mem_fetch got %0d want 6", trp); end
  endtask

  task automatic test_fpu;
    ins_t p[$];
    int cyc; bit done;
    p.push_back(mk(OP_F32C, 64'h3F80_0000));
    p.push_back(mk(OP_END, 0));
    load(p, 3);
    exec_prog(3, 0, 1'b0, 20, cyc, done);
    n_chk++; if (res !== 64'h3F80_0000) begin n_fail++; $display("FAIL f32_result got %h want 3f800000", res); end
    n_chk++; if (rty !== 2'd2) begin n_fail++; $display("FAIL f32_type got %0d want 2", rty); end
    exec_prog(3, 0, 1'b1, 20, cyc, done);
    n_chk++; if (trp_n !== 4'd7) begin n_fail++; $display("FAIL nofpu_trap got %0d want 7", trp_n); end
    p.delete();
    p.push_back(mk(OP_F64C, 64'h4009_21FB_5444_2D18));
    p.push_back(mk(OP_END, 0));
    load(p, 3);
    exec_prog(3, 0, 1'b0, 20, cyc, done);
    n_chk++; if (res !== 64'h4009_21FB_5444_2D18) begin n_fail++; $display("FAIL f64_result got %h want 400921fb54442d18", res); end
    n_chk++; if (rty !== 2'd3) begin n_fail++; $display("FAIL f64_type got %0d want 3", rty); end
  endtask

  task automatic test_reset_mid;
    ins_t p[$];
    int cyc; bit done;
    logic [63:0] r1;
    p.push_back(mk(OP_I32C, 1000)); p.push_back(mk(OP_I32C, -77));
    p.push_back(mk(OP_I32ADD, 0)); p.push_back(mk(OP_END, 0));
    load(p, 9);
    exec_prog(9, 0, 1'b0, 30, cyc, done);
    r1 = res;
    n_chk++; if (r1 !== 64'd923) begin n_fail++; $display("FAIL mid_first got %h want 39b", r1); end
    exec_prog(9, 0, 1'b0, 5, cyc, done);
    reset = 1'b1;
    #2;
    n_chk++; if (trp !== 4'd0) begin n_fail++; $display("FAIL mid_trap got %0d want 0", trp); end
    n_chk++; if (remp !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %0b want 1", remp); end
    n_chk++; if (res !== 64'd0) begin n_fail++; $display("FAIL mid_result got %h want 0", res); end
    n_chk++; if (maddr !== 7'd9) begin n_fail++; $display("FAIL mid_addr got %0d want 9", maddr); end
    exec_prog(9, 0, 1'b0, 30, cyc, done);
    n_chk++; if (res !== r1 || trp !== 4'd1) begin n_fail++; $display("FAIL mid_rerun got %h/%0d want %h/1", res, trp, r1); end
  endtask

  task automatic test_random;
    ins_t p[$];
    int cyc, base, start, n, r, et, ety;
    bit done, ee;
    logic [63:0] ev;
    for (int it = 0; it < 30; it++) begin
      p.delete();
      base  = $urandom_range(0, 2);
      start = $urandom_range(0, 20);
      for (int l = 0; l < base; l++) begin
        p.push_back(mk(OP_I32C, longint'(int'($urandom))));
        p.push_back(mk(OP_SET, l));
      end
      n = $urandom_range(3, 8);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 10);
        case (r)
          0, 1: p.push_back(mk(OP_I32C, longint'(int'($urandom))));
          2, 3: p.push_back(mk(OP_I64C, longint'({$urandom, $urandom}) >>> $urandom_range(0, 63)));
          4: p.push_back(mk(OP_I32ADD, 0));
          5: p.push_back(mk(OP_I64ADD, 0));
          6: p.push_back(mk(OP_DROP, 0));
          7: p.push_back(base > 0 ? mk(OP_GET, $urandom_range(0, base - 1)) : mk(OP_NOP, 0));
          8: p.push_back(base > 0 ? mk(OP_SET, $urandom_range(0, base - 1)) : mk(OP_NOP, 0));
          9: p.push_back(base > 0 ? mk(OP_TEE, $urandom_range(0, base - 1)) : mk(OP_NOP, 0));
          default: p.push_back(j[0] ? mk(OP_F32C, longint'($urandom)) : mk(OP_F64C, longint'({$urandom, $urandom})));
        endcase
      end
      p.push_back(mk(OP_END, 0));
      load(p, start);
      model(p, base, 1'b1, 1'b1, et, ev, ety, ee);
      exec_prog(start, base, 1'b0, 4 * (p.size() + 2) + 8, cyc, done);
      n_chk++; if (trp !== 4'(et)) begin n_fail++; $display("FAIL rand%0d_trap got %0d want %0d", it, trp, et); end
      n_chk++; if (remp !== ee) begin n_fail++; $display("FAIL rand%0d_empty got %0b want %0b", it, remp, ee); end
      if (!ee) begin
        n_chk++; if (res !== ev || rty !== 2'(ety)) begin n_fail++; $display("FAIL rand%0d_top got %h/%0d want %h/%0d", it, res, rty, ev, ety); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_i64_locals;
    test_i32_add;
    test_stack_errors;
    test_mem_bounds;
    test_fpu;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
